// File: rtl/hex_emitter_pkg.sv
// Shared types and constants for the hex character emitter.
// Covers the FSM state type, ASCII code points and the digit-count helper.
package hex_emitter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        NL   = 2'd2
    } state_t;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] UA   = 8'h41;
    localparam logic [7:0] LA   = 8'h61;
    localparam logic [7:0] LF   = 8'h0A;

    function automatic int ndig(input int w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational map from one hex nibble to its ASCII digit.
// The UPPERCASE parameter selects 'A'-'F' or 'a'-'f'.
module hex_nibble_to_ascii
    import hex_emitter_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] char_o
);

    always_comb begin
        char_o = ZERO + {4'b0000, nibble_i};
        if (nibble_i > 4'd9) begin
            char_o = (UPPERCASE ? UA : LA) + {4'b0000, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_char_emitter.sv
// Streams each accepted word as ASCII hex digits, most significant digit first.
// Define HEX_EMITTER_NEWLINE_EN to append a 0x0A character after every word.
module hex_char_emitter
    import hex_emitter_pkg::*;
#(
    parameter int DATA_W    = 9,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              busy,
    output logic [15:0]       words_done
);

    localparam int NDIG   = ndig(DATA_W);
    localparam int WORD_W = 4 * NDIG;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [7:0]        out_char_q;
    logic [15:0]       words_done_q;

    logic [WORD_W-1:0] in_word;
    logic [IDX_W-1:0]  idx_m1;
    logic [WORD_W-1:0] word_shifted;
    logic [3:0]        nib_d;
    logic [7:0]        char_d;

    // The converter is fed the nibble that will be shown after the next
    // handshake, so out_char can be loaded as a registered value.
    always_comb begin
        in_word      = WORD_W'(in_data);
        idx_m1       = idx_q - 1'b1;
        word_shifted = word_q >> {idx_m1, 2'b00};
        nib_d        = in_word[WORD_W-1 -: 4];
        if (state_q == EMIT) begin
            nib_d = word_shifted[3:0];
        end
    end

    hex_nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nib2ascii (
        .nibble_i (nib_d),
        .char_o   (char_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_char_q   <= '0;
            words_done_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        word_q      <= in_word;
                        idx_q       <= IDX_W'(NDIG - 1);
                        out_valid_q <= 1'b1;
                        out_char_q  <= char_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= EMIT;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx_q != '0) begin
                            idx_q      <= idx_m1;
                            out_char_q <= char_d;
                        end else begin
`ifdef HEX_EMITTER_NEWLINE_EN
                            out_char_q   <= LF;
                            state_q      <= NL;
`else
                            words_done_q <= words_done_q + 16'd1;
                            out_valid_q  <= 1'b0;
                            in_ready_q   <= 1'b1;
                            state_q      <= IDLE;
`endif
                        end
                    end
                end
`ifdef HEX_EMITTER_NEWLINE_EN
                NL: begin
                    if (out_ready) begin
                        words_done_q <= words_done_q + 16'd1;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
`endif
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;
    assign busy       = (state_q != IDLE);
    assign words_done = words_done_q;

endmodule
